// File: rtl/memgame_autoplayer.sv
// Automated responder for memgame: captures the presented symbol sequence from led, replays it on predict/loadIN.
// Optional MEMGAME_AP_FAULT_EN adds an inject input that corrupts bit 0 of the last replayed symbol.
module memgame_autoplayer #(
  parameter int MAX_LEN        = 16,
  parameter int PRESS_HIGH     = 1,
  parameter int PRESS_GAP      = 2,
  parameter int RESULT_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       arm,
`ifdef MEMGAME_AP_FAULT_EN
  input  logic       inject,
`endif
  input  logic [7:0] led,
  output logic       startIN,
  output logic [3:0] predict,
  output logic       loadIN,
  output logic       busy,
  output logic       win,
  output logic       lose,
  output logic       overflow,
  output logic [4:0] seq_len
);

  // state     | meaning
  // S_IDLE    | waiting for arm rising edge
  // S_START   | startIN raised, one cycle before capture
  // S_CAPTURE | recording symbols on led[7] rising edges
  // S_SETUP   | predict loaded from buffer
  // S_PRESS   | loadIN high for PRESS_HIGH cycles
  // S_GAP     | loadIN low for PRESS_GAP cycles, then next entry
  // S_RESULT  | waiting for win/lose pattern or timeout
  // S_DONE    | game finished, back to idle
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_CAPTURE, S_SETUP, S_PRESS, S_GAP, S_RESULT, S_DONE
  } state_t;

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(RESULT_TIMEOUT + PRESS_HIGH + PRESS_GAP + 1);

  state_t        state_q, state_d;
  logic          arm_q;
  logic          led7_q;
  logic [4:0]    wr_ptr;
  logic [4:0]    rd_ptr;
  logic [TW-1:0] timer;
  logic [3:0]    sym_mem [0:MAX_LEN-1];
  logic          arm_rise;
  logic          led_rise;
  logic          result_seen;
  logic          last_entry;
  logic [3:0]    next_predict;
`ifdef MEMGAME_AP_FAULT_EN
  logic          inject_q;
`endif

  assign arm_rise    = arm & ~arm_q;
  assign led_rise    = led[7] & ~led7_q;
  assign result_seen = (led == 8'hFF) || (led == 8'h0F);
  assign last_entry  = (rd_ptr + 5'd1 == wr_ptr);
  assign seq_len     = wr_ptr;

`ifdef MEMGAME_AP_FAULT_EN
  assign next_predict = sym_mem[rd_ptr[AW-1:0]] ^ {3'b000, inject_q & last_entry};
`else
  assign next_predict = sym_mem[rd_ptr[AW-1:0]];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    startIN = 1'b0;
    loadIN  = 1'b0;
    busy    = 1'b0;
    case (state_q)
      S_IDLE:    if (arm_rise) state_d = S_START;
      S_START: begin
        startIN = 1'b1;
        busy    = 1'b1;
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        startIN = 1'b1;
        busy    = 1'b1;
        if (led[6] && !led[7]) state_d = (wr_ptr == 5'd0) ? S_RESULT : S_SETUP;
      end
      S_SETUP: begin
        startIN = 1'b1;
        busy    = 1'b1;
        state_d = S_PRESS;
      end
      S_PRESS: begin
        startIN = 1'b1;
        busy    = 1'b1;
        loadIN  = 1'b1;
        if (timer == '0) state_d = S_GAP;
      end
      S_GAP: begin
        startIN = 1'b1;
        busy    = 1'b1;
        if (timer == '0) state_d = last_entry ? S_RESULT : S_SETUP;
      end
      S_RESULT: begin
        startIN = 1'b1;
        busy    = 1'b1;
        if (result_seen || timer == '0) state_d = S_DONE;
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arm_q    <= 1'b0;
      led7_q   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      timer    <= '0;
      predict  <= '0;
      win      <= 1'b0;
      lose     <= 1'b0;
      overflow <= 1'b0;
`ifdef MEMGAME_AP_FAULT_EN
      inject_q <= 1'b0;
`endif
    end else begin
      arm_q  <= arm;
      led7_q <= led[7];
      case (state_q)
        S_IDLE: if (arm_rise) begin
          win      <= 1'b0;
          lose     <= 1'b0;
          overflow <= 1'b0;
          wr_ptr   <= '0;
`ifdef MEMGAME_AP_FAULT_EN
          inject_q <= inject;
`endif
        end
        S_CAPTURE: begin
          if (led_rise) begin
            if (wr_ptr == 5'(MAX_LEN)) overflow <= 1'b1;
            else                       wr_ptr   <= wr_ptr + 5'd1;
          end
          rd_ptr <= '0;
          timer  <= TW'(RESULT_TIMEOUT - 1);
        end
        S_SETUP: begin
          predict <= next_predict;
          timer   <= TW'(PRESS_HIGH - 1);
        end
        S_PRESS: begin
          if (timer == '0) timer <= TW'(PRESS_GAP - 1);
          else             timer <= timer - TW'(1);
        end
        S_GAP: begin
          if (timer == '0) begin
            rd_ptr <= rd_ptr + 5'd1;
            timer  <= TW'(RESULT_TIMEOUT - 1);
          end else begin
            timer  <= timer - TW'(1);
          end
        end
        S_RESULT: begin
          // a real result pattern takes precedence over a coincident timeout
          if (led == 8'hFF)                       win  <= 1'b1;
          else if (led == 8'h0F || timer == '0)   lose <= 1'b1;
          if (timer != '0) timer <= timer - TW'(1);
        end
        default: ;
      endcase
    end
  end

  // buffer contents need no reset
  always_ff @(posedge clk) begin
    if (state_q == S_CAPTURE && led_rise && wr_ptr != 5'(MAX_LEN))
      sym_mem[wr_ptr[AW-1:0]] <= led[3:0];
  end

endmodule
